mpu_operand_loader: RTL
=======================

// Module: mpu_operand_loader
// PURPOSE
//  Upstream feeder for the MPU operation stage. Receives a byte-serial command
//  stream (header, size, factor, matrix A, optional matrix B) over a valid/ready
//  handshake, and assembles the flat 5x5 operand vectors. Presents operation/size/
//  factor/matrices as stable registers, then pulses start and holds them while the
//  operation stage computes.
// PARAMETERS
//  ELEM_W       8   element width in bits (signed int8)
//  ELEMS        25  elements per matrix (5x5, row-major)
//  HOLD_CYCLES  8   cycles operands stay frozen after start before next header accepted
// PORTS
//  clock      in   1        sole clock, rising edge
//  reset      in   1        synchronous, active-high
//  in_data    in   8        command byte
//  in_valid   in   1        in_data valid
//  in_ready   out  1        loader accepts byte this cycle (transfer = valid & ready)
//  operation  out  3        opcode to operation stage
//  size       out  8        matrix order
//  factor     out  8        signed scalar for integer multiply
//  matrix_a   out  200      flat operand A; element k at bits [8k:8k+7], ascending index (elem 0 = MSB byte)
//  matrix_b   out  200      flat operand B, same layout
//  start      out  1        one-cycle pulse: operands valid and stable
//  busy       out  1        high in every state except HDR
//  cmd_error  out  1        sticky: last command rejected; cleared on next accepted header
// BEHAVIOUR
//  Reset: state=HDR; all outputs 0 except in_ready=1; counter=0.
//  Byte order: HDR{[7:3] ignored,[2:0] opcode}, SIZE, FACTOR, A[0..24], B[0..24] (row-major).
//  FSM: HDR -> SIZE -> FACTOR -> LOAD_A -> (LOAD_B if needs_b) -> ISSUE -> HOLD -> HDR.
//   Each of HDR..LOAD_B advances only on a transfer; in_valid low = stall, no state change.
//   needs_b = opcode in {0 add, 1 conv, 6 mul}; else LOAD_B skipped and matrix_b stays 0.
//   HDR transfer: latch operation; clear matrix_a, matrix_b, cmd_error.
//   LOAD_A/LOAD_B: 5-bit counter 0..ELEMS-1 selects slot; at count=24 transfer, counter->0, next state.
//   ISSUE: in_ready=0; start=1 for exactly this cycle, unless command invalid.
//   HOLD: in_ready=0; counts HOLD_CYCLES cycles; outputs frozen; then HDR.
//  Validation: invalid if opcode==7 or size not in 2..5. Invalid command still consumes
//   its full byte sequence (B per needs_b; opcode 7 treated as no-B); at ISSUE start stays 0,
//   cmd_error set to 1, and FSM goes directly to HDR (HOLD skipped).
//  in_ready is a registered state decode: 1 exactly in HDR/SIZE/FACTOR/LOAD_A/LOAD_B.
//  Back-to-back: first header byte of next command is accepted on the cycle after HOLD ends.
//  Reset mid-load: partial command discarded, all registers to reset values next cycle.
//  Elements stored verbatim; no sign extension or arithmetic performed here.
// STRUCTURE
//  Shared package mpu_pkg: opcode constants (OP_ADD=0..OP_MUL=6), ELEM_W, ELEMS,
//   MATRIX_W=200, loader state enum, function needs_b(opcode).
//  Single module; no sub-module. Matrix write = indexed part-select from counter.
// TESTING
//  1 add: hdr 0x00,size 5,factor 0,A=1..25,B=25..1 -> one start pulse, matrix_a[0:7]=1, matrix_b[0:7]=25, 53 transfers.
//  2 opposite: hdr 0x03,size 3,A bytes only (28 transfers) -> start after A[24]; matrix_b==0; in_ready=0 for 1+8 cycles.
//  3 stall: in_valid toggled every other cycle during load -> identical outputs to case 1, start once.
//  4 invalid: hdr 0x07 then size 9 command -> start never asserts, cmd_error=1, next valid hdr clears it.
//  5 reset at A[10]: reset high 1 cycle -> outputs 0, state HDR; fresh command completes normally.
//  6 imul: factor 0xFE -> factor=-2 held stable from start through HOLD; busy falls after HOLD.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU front end: opcodes, operand geometry and
// the operand loader state encoding.
package mpu_pkg;

   localparam int ELEM_W   = 8;
   localparam int ELEMS    = 25;
   localparam int MATRIX_W = ELEM_W * ELEMS;

   localparam logic [2:0] OP_ADD       = 3'd0;
   localparam logic [2:0] OP_CONV      = 3'd1;
   localparam logic [2:0] OP_TRANSPOSE = 3'd2;
   localparam logic [2:0] OP_OPPOSITE  = 3'd3;
   localparam logic [2:0] OP_DET       = 3'd4;
   localparam logic [2:0] OP_IMUL      = 3'd5;
   localparam logic [2:0] OP_MUL       = 3'd6;
   localparam logic [2:0] OP_INVALID   = 3'd7;

   typedef enum logic [2:0] {
      ST_HDR,
      ST_SIZE,
      ST_FACTOR,
      ST_LOAD_A,
      ST_LOAD_B,
      ST_ISSUE,
      ST_HOLD
   } loader_state_t;

   // Only the two-operand operations carry a B matrix in the command stream.
   function automatic logic needs_b(input logic [2:0] opcode);
      return (opcode == OP_ADD) || (opcode == OP_CONV) || (opcode == OP_MUL);
   endfunction

endpackage

// File: rtl/mpu_operand_loader.sv
// Byte-serial command loader: assembles opcode, size, factor and the flat 5x5
// operand matrices, then issues a start pulse and freezes them for the operation stage.
module mpu_operand_loader
   import mpu_pkg::*;
#(
   parameter int HOLD_CYCLES = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [2:0]           operation,
   output logic [7:0]           size,
   output logic [7:0]           factor,
   output logic [0:MATRIX_W-1]  matrix_a,
   output logic [0:MATRIX_W-1]  matrix_b,
   output logic                 start,
   output logic                 busy,
   output logic                 cmd_error,
   output loader_state_t        state
);

   // Handshake: a byte moves when in_valid && in_ready at a rising edge; in_ready
   // depends only on the state register, never on in_valid.
   loader_state_t next_state;
   logic [4:0]    count;
   logic          xfer;
   logic          last_elem;
   logic          last_hold;
   logic          cmd_invalid;

   always_comb begin
      in_ready    = (state == ST_HDR) || (state == ST_SIZE) || (state == ST_FACTOR) ||
                    (state == ST_LOAD_A) || (state == ST_LOAD_B);
      busy        = (state != ST_HDR);
      xfer        = in_valid && in_ready;
      last_elem   = (count == 5'(ELEMS - 1));
      last_hold   = (count == 5'(HOLD_CYCLES - 1));
      cmd_invalid = (operation == OP_INVALID) || (size < 8'd2) || (size > 8'd5);
      start       = (state == ST_ISSUE) && !cmd_invalid;
   end

   always_ff @(posedge clock) begin
      if (reset) state <= ST_HDR;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_HDR:    if (xfer) next_state = ST_SIZE;
         ST_SIZE:   if (xfer) next_state = ST_FACTOR;
         ST_FACTOR: if (xfer) next_state = ST_LOAD_A;
         ST_LOAD_A: if (xfer && last_elem) next_state = needs_b(operation) ? ST_LOAD_B : ST_ISSUE;
         ST_LOAD_B: if (xfer && last_elem) next_state = ST_ISSUE;
         ST_ISSUE:  next_state = cmd_invalid ? ST_HDR : ST_HOLD;
         ST_HOLD:   if (last_hold) next_state = ST_HDR;
         default:   next_state = ST_HDR;
      endcase
   end

   // The element counter doubles as the hold timer; both phases end with it at zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         operation <= '0;
         size      <= '0;
         factor    <= '0;
         matrix_a  <= '0;
         matrix_b  <= '0;
         cmd_error <= 1'b0;
         count     <= '0;
      end else begin
         case (state)
            ST_HDR: if (xfer) begin
               operation <= in_data[2:0];
               matrix_a  <= '0;
               matrix_b  <= '0;
               cmd_error <= 1'b0;
            end
            ST_SIZE:   if (xfer) size <= in_data;
            ST_FACTOR: if (xfer) factor <= in_data;
            ST_LOAD_A: if (xfer) begin
               matrix_a[count*ELEM_W +: ELEM_W] <= in_data;
               count <= last_elem ? 5'd0 : count + 5'd1;
            end
            ST_LOAD_B: if (xfer) begin
               matrix_b[count*ELEM_W +: ELEM_W] <= in_data;
               count <= last_elem ? 5'd0 : count + 5'd1;
            end
            ST_ISSUE: if (cmd_invalid) cmd_error <= 1'b1;
            ST_HOLD:  count <= last_hold ? 5'd0 : count + 5'd1;
            default: ;
         endcase
      end
   end

endmodule
